env_write_arbiter: RTL and testbench

//  Shares the environment grid's single write port between the setup client (initializer placing

---
 rtl/env_write_arbiter_pkg.sv | 27 ++
 rtl/env_write_arbiter_rr_pick.sv | 48 ++++
 rtl/env_write_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_env_write_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/env_write_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// env_write_arbiter_pkg
// Shared types and widths for the environment-grid write arbiter.
//   env_wr_t    : one write request payload (x, y, signal, sugar)
//   arb_state_t : arbiter phase (setup client only, ant round-robin, paused)
// ---------------------------------------------------------------------------
package env_write_arbiter_pkg;

  localparam int ARB_NUM_REQ  = 8;
  localparam int ARB_X_BITS   = 8;
  localparam int ARB_Y_BITS   = 7;
  localparam int ARB_SIG_BITS = 4;

  typedef struct packed {
    logic [ARB_X_BITS-1:0]   x;
    logic [ARB_Y_BITS-1:0]   y;
    logic [ARB_SIG_BITS-1:0] signal;
    logic                    sugar;
  } env_wr_t;

  typedef enum logic [1:0] {
    ARB_SETUP  = 2'd0,
    ARB_RUN    = 2'd1,
    ARB_PAUSED = 2'd2
  } arb_state_t;

endpackage

// File: rtl/env_write_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// env_write_arbiter_rr_pick
// Combinational rotating priority encoder: the first set bit of i_req found
// when scanning upward from i_ptr (wrapping) wins.
//   i_req   : request vector
//   i_ptr   : index with highest priority
//   o_gnt   : one-hot winner (all zero when nothing requests)
//   o_valid : any request present
//   o_idx   : binary index of the winner
// ---------------------------------------------------------------------------
module env_write_arbiter_rr_pick #(
  parameter int NUM_REQ  = 8,
  parameter int PTR_BITS = 3
) (
  input  logic [NUM_REQ-1:0]  i_req,
  input  logic [PTR_BITS-1:0] i_ptr,
  output logic [NUM_REQ-1:0]  o_gnt,
  output logic                o_valid,
  output logic [PTR_BITS-1:0] o_idx
);

  localparam logic [PTR_BITS:0] LP_N = (PTR_BITS+1)'(NUM_REQ);

  // Scan from the pointer and latch the first requester found.
  always_comb begin
    logic [PTR_BITS:0] v_sum;
    o_gnt   = '0;
    o_valid = 1'b0;
    o_idx   = '0;
    v_sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      v_sum = {1'b0, i_ptr} + (PTR_BITS+1)'(k);
      if (v_sum >= LP_N) begin
        v_sum = v_sum - LP_N;
      end else begin
        v_sum = v_sum;
      end
      if (!o_valid && i_req[v_sum[PTR_BITS-1:0]]) begin
        o_valid                        = 1'b1;
        o_idx                          = v_sum[PTR_BITS-1:0];
        o_gnt[v_sum[PTR_BITS-1:0]]     = 1'b1;
      end else begin
        o_valid = o_valid;
      end
    end
  end

endmodule

// File: rtl/env_write_arbiter.sv
// ---------------------------------------------------------------------------
// env_write_arbiter
// Shares the environment grid's single write port between the setup client
// and NUM_REQ ants. Setup client only in setup phase; ants round-robin in run
// phase; PAUSE freezes ant writes with a pause_ack handshake. All outputs are
// registered: requests seen at edge k produce gnt + write in cycle k+1.
//   Clk, RESET_SIM_N        : clock, async active-low reset
//   SETUP_PHASE, PAUSE      : phase select, pause request
//   pause_ack               : high while paused
//   setup_req/wr/gnt        : setup client handshake and payload
//   ant_req/wr/gnt          : per-ant handshake and payload
//   wr_en, wr_x, wr_y,
//   wr_signal, wr_sugar     : environment write port (data holds when idle)
//   grant_count             : saturating count of ant grants
// ---------------------------------------------------------------------------
module env_write_arbiter
  import env_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ
) (
  input  logic                    Clk,
  input  logic                    RESET_SIM_N,
  input  logic                    SETUP_PHASE,
  input  logic                    PAUSE,
  output logic                    pause_ack,
  input  logic                    setup_req,
  input  env_wr_t                 setup_wr,
  output logic                    setup_gnt,
  input  logic [NUM_REQ-1:0]      ant_req,
  input  env_wr_t [NUM_REQ-1:0]   ant_wr,
  output logic [NUM_REQ-1:0]      ant_gnt,
  output logic                    wr_en,
  output logic [ARB_X_BITS-1:0]   wr_x,
  output logic [ARB_Y_BITS-1:0]   wr_y,
  output logic [ARB_SIG_BITS-1:0] wr_signal,
  output logic                    wr_sugar,
  output logic [15:0]             grant_count
);

  localparam int PTR_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_BITS-1:0] LP_LAST = PTR_BITS'(NUM_REQ - 1);

  arb_state_t            r_state;
  arb_state_t            w_next_state;
  logic [PTR_BITS-1:0]   r_rr_ptr;
  logic [PTR_BITS-1:0]   w_next_ptr;
  logic                  r_setup_gnt;
  logic [NUM_REQ-1:0]    r_ant_gnt;
  logic                  r_wr_en;
  env_wr_t               r_wr;
  logic                  r_pause_ack;
  logic [15:0]           r_grant_count;

  logic [NUM_REQ-1:0]    w_elig;
  logic [NUM_REQ-1:0]    w_pick_gnt;
  logic                  w_pick_valid;
  logic [PTR_BITS-1:0]   w_pick_idx;
  logic                  w_do_setup;
  logic                  w_do_ant;
  env_wr_t               w_sel;

  // A client granted this cycle sits out the next arbitration.
  assign w_elig = ant_req & ~r_ant_gnt;

  env_write_arbiter_rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .PTR_BITS (PTR_BITS)
  ) u_pick (
    .i_req   (w_elig),
    .i_ptr   (r_rr_ptr),
    .o_gnt   (w_pick_gnt),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  // Phase transitions and grant decision. A grant is only issued on an edge
  // where the arbiter stays in its serving state, so leaving SETUP or RUN
  // never completes a write on the same edge.
  always_comb begin
    w_next_state = r_state;
    w_do_setup   = 1'b0;
    w_do_ant     = 1'b0;
    case (r_state)
      ARB_SETUP: begin
        w_do_setup = SETUP_PHASE & setup_req & ~r_setup_gnt;
        if (!SETUP_PHASE) begin
          w_next_state = ARB_RUN;
        end else begin
          w_next_state = ARB_SETUP;
        end
      end
      ARB_RUN: begin
        w_do_ant = ~SETUP_PHASE & ~PAUSE & w_pick_valid;
        if (SETUP_PHASE) begin
          w_next_state = ARB_SETUP;
        end else if (PAUSE) begin
          w_next_state = ARB_PAUSED;
        end else begin
          w_next_state = ARB_RUN;
        end
      end
      ARB_PAUSED: begin
        if (SETUP_PHASE) begin
          w_next_state = ARB_SETUP;
        end else if (!PAUSE) begin
          w_next_state = ARB_RUN;
        end else begin
          w_next_state = ARB_PAUSED;
        end
      end
      default: begin
        w_next_state = ARB_SETUP;
      end
    endcase
  end

  // Round-robin pointer: restart at 0 on entry to run, advance past a winner.
  always_comb begin
    w_next_ptr = r_rr_ptr;
    if (r_state == ARB_SETUP && w_next_state == ARB_RUN) begin
      w_next_ptr = '0;
    end else if (w_do_ant) begin
      if (w_pick_idx == LP_LAST) begin
        w_next_ptr = '0;
      end else begin
        w_next_ptr = w_pick_idx + PTR_BITS'(1);
      end
    end else begin
      w_next_ptr = r_rr_ptr;
    end
  end

  // Payload of whichever client wins this edge.
  always_comb begin
    if (w_do_setup) begin
      w_sel = setup_wr;
    end else begin
      w_sel = ant_wr[w_pick_idx];
    end
  end

  // State, grants, write port and debug counter.
  always_ff @(posedge Clk or negedge RESET_SIM_N) begin
    if (!RESET_SIM_N) begin
      r_state       <= ARB_SETUP;
      r_rr_ptr      <= '0;
      r_setup_gnt   <= 1'b0;
      r_ant_gnt     <= '0;
      r_wr_en       <= 1'b0;
      r_wr          <= '0;
      r_pause_ack   <= 1'b0;
      r_grant_count <= 16'd0;
    end else begin
      r_state     <= w_next_state;
      r_rr_ptr    <= w_next_ptr;
      r_setup_gnt <= w_do_setup;
      r_ant_gnt   <= w_do_ant ? w_pick_gnt : '0;
      r_wr_en     <= w_do_setup | w_do_ant;
      r_pause_ack <= (w_next_state == ARB_PAUSED);
      if (w_do_setup || w_do_ant) begin
        r_wr <= w_sel;
      end else begin
        r_wr <= r_wr;
      end
      if (w_do_ant && (r_grant_count != 16'hFFFF)) begin
        r_grant_count <= r_grant_count + 16'd1;
      end else begin
        r_grant_count <= r_grant_count;
      end
    end
  end

  assign pause_ack   = r_pause_ack;
  assign setup_gnt   = r_setup_gnt;
  assign ant_gnt     = r_ant_gnt;
  assign wr_en       = r_wr_en;
  assign wr_x        = r_wr.x;
  assign wr_y        = r_wr.y;
  assign wr_signal   = r_wr.signal;
  assign wr_sugar    = r_wr.sugar;
  assign grant_count = r_grant_count;

endmodule

// File: tb/tb_env_write_arbiter.sv
module tb_env_write_arbiter;
  import env_write_arbiter_pkg::*;

  localparam int N = 8;

  logic           Clk = 1'b0;
  logic           RESET_SIM_N;
  logic           SETUP_PHASE, PAUSE, setup_req;
  env_wr_t        setup_wr;
  env_wr_t [N-1:0] ant_wr;
  logic [N-1:0]   ant_req;
  logic           pause_ack, setup_gnt, wr_en, wr_sugar;
  logic [N-1:0]   ant_gnt;
  logic [7:0]     wr_x;
  logic [6:0]     wr_y;
  logic [3:0]     wr_signal;
  logic [15:0]    grant_count;

  int total = 0;
  int bad   = 0;

  // Reference model: mode 0=setup, 1=run, 2=paused
  int          m_mode, m_ptr, m_count;
  logic        m_setup_gnt, m_wr_en, m_pause_ack;
  logic [N-1:0] m_ant_gnt;
  env_wr_t     m_wr;

  always #5 Clk = ~Clk;

  env_write_arbiter dut (
    .Clk(Clk), .RESET_SIM_N(RESET_SIM_N), .SETUP_PHASE(SETUP_PHASE), .PAUSE(PAUSE),
    .pause_ack(pause_ack), .setup_req(setup_req), .setup_wr(setup_wr), .setup_gnt(setup_gnt),
    .ant_req(ant_req), .ant_wr(ant_wr), .ant_gnt(ant_gnt), .wr_en(wr_en),
    .wr_x(wr_x), .wr_y(wr_y), .wr_signal(wr_signal), .wr_sugar(wr_sugar),
    .grant_count(grant_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_ptr = 0; m_count = 0;
    m_setup_gnt = 1'b0; m_wr_en = 1'b0; m_pause_ack = 1'b0;
    m_ant_gnt = '0; m_wr = '0;
  endtask

  task automatic randomize_data();
    for (int i = 0; i < N; i++) begin
      ant_wr[i].x      = 8'($urandom);
      ant_wr[i].y      = 7'($urandom);
      ant_wr[i].signal = 4'($urandom);
      ant_wr[i].sugar  = 1'($urandom);
    end
  endtask

  // Apply the arbitration rules to the inputs present before the coming edge.
  task automatic model_step();
    logic         sg;
    logic [N-1:0] ag;
    int           nmode;
    sg = 1'b0; ag = '0;
    if (m_mode == 0) begin
      if (SETUP_PHASE && setup_req && !m_setup_gnt) begin
        sg = 1'b1; m_wr = setup_wr;
      end
      nmode = SETUP_PHASE ? 0 : 1;
      if (nmode == 1) m_ptr = 0;
    end else begin
      if (m_mode == 1 && !SETUP_PHASE && !PAUSE) begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_ptr + k) % N;
          if (ag == '0 && ant_req[i] && !m_ant_gnt[i]) begin
            ag[i] = 1'b1;
            m_wr = ant_wr[i];
            m_ptr = (i + 1) % N;
            if (m_count < 65535) m_count = m_count + 1;
          end
        end
      end
      nmode = SETUP_PHASE ? 0 : (PAUSE ? 2 : 1);
    end
    m_mode      = nmode;
    m_setup_gnt = sg;
    m_ant_gnt   = ag;
    m_wr_en     = sg | (ag != '0);
    m_pause_ack = (nmode == 2);
  endtask

  task automatic compare_all(input string ph);
    check({ph, ".setup_gnt"}, 32'(setup_gnt), 32'(m_setup_gnt));
    check({ph, ".ant_gnt"},   32'(ant_gnt),   32'(m_ant_gnt));
    check({ph, ".wr_en"},     32'(wr_en),     32'(m_wr_en));
    check({ph, ".wr_x"},      32'(wr_x),      32'(m_wr.x));
    check({ph, ".wr_y"},      32'(wr_y),      32'(m_wr.y));
    check({ph, ".wr_signal"}, 32'(wr_signal), 32'(m_wr.signal));
    check({ph, ".wr_sugar"},  32'(wr_sugar),  32'(m_wr.sugar));
    check({ph, ".pause_ack"}, 32'(pause_ack), 32'(m_pause_ack));
    check({ph, ".grant_count"}, 32'(grant_count), 32'(m_count));
  endtask

  task automatic cycle(input string ph);
    model_step();
    @(posedge Clk);
    #1;
    compare_all(ph);
  endtask

  initial begin
    bit got2;
    RESET_SIM_N = 1'b0; SETUP_PHASE = 1'b1; PAUSE = 1'b0; setup_req = 1'b0;
    setup_wr = '0; ant_req = '0; ant_wr = '0;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    compare_all("reset");
    @(negedge Clk);
    RESET_SIM_N = 1'b1;
    @(posedge Clk); #1;

    // Setup client served, ants ignored
    setup_req = 1'b1;
    setup_wr.x = 8'd10; setup_wr.y = 7'd20; setup_wr.signal = 4'd0; setup_wr.sugar = 1'b1;
    ant_req = 8'hFF; randomize_data();
    cycle("setup1");
    check("setup1.gnt_direct", 32'(setup_gnt), 32'd1);
    check("setup1.x_direct", 32'(wr_x), 32'd10);
    for (int c = 0; c < 4; c++) begin
      setup_wr.x = 8'($urandom); setup_wr.y = 7'($urandom);
      cycle("setup_hold");
    end
    check("setup.ants_blocked", 32'(grant_count), 32'd0);

    // Run: all ants request, round-robin with wrap
    setup_req = 1'b0; SETUP_PHASE = 1'b0;
    cycle("to_run");
    for (int c = 0; c < 8; c++) begin
      randomize_data();
      cycle("rr_all");
    end
    check("rr.count8", 32'(grant_count), 32'd8);
    for (int c = 0; c < 8; c++) begin
      randomize_data();
      cycle("rr_wrap");
    end

    // Only ant 5 requests
    ant_req = 8'h20;
    for (int c = 0; c < 6; c++) begin
      randomize_data();
      cycle("ant5");
    end

    // Pause handshake with ant 3 waiting
    ant_req = 8'h08; PAUSE = 1'b1;
    cycle("pause_enter");
    cycle("pause_hold");
    check("pause.ack_direct", 32'(pause_ack), 32'd1);
    PAUSE = 1'b0;
    cycle("pause_exit");
    cycle("ant3_after_pause");

    // Setup and pause requested together mid-stream
    ant_req = 8'hFF;
    cycle("stream");
    cycle("stream");
    SETUP_PHASE = 1'b1; PAUSE = 1'b1; setup_req = 1'b1;
    setup_wr.x = 8'd77; setup_wr.y = 7'd5; setup_wr.signal = 4'd9; setup_wr.sugar = 1'b0;
    cycle("setup_and_pause");
    PAUSE = 1'b0;
    for (int c = 0; c < 3; c++) cycle("back_to_setup");

    // Async reset while ant 2 holds the grant
    setup_req = 1'b0; SETUP_PHASE = 1'b0; ant_req = 8'h04;
    got2 = 1'b0;
    for (int c = 0; c < 4 && !got2; c++) begin
      randomize_data();
      cycle("seek_ant2");
      got2 = m_ant_gnt[2];
    end
    check("seek_ant2.reached", 32'(got2), 32'd1);
    RESET_SIM_N = 1'b0;
    #1;
    check("async.ant_gnt", 32'(ant_gnt), 32'd0);
    check("async.wr_en", 32'(wr_en), 32'd0);
    check("async.grant_count", 32'(grant_count), 32'd0);
    model_reset();
    @(negedge Clk);
    RESET_SIM_N = 1'b1;
    SETUP_PHASE = 1'b1;
    @(posedge Clk); #1;

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 19) == 0) SETUP_PHASE = ~SETUP_PHASE;
      PAUSE     = ($urandom_range(0, 7) == 0);
      setup_req = 1'($urandom);
      ant_req   = 8'($urandom);
      setup_wr.x = 8'($urandom); setup_wr.y = 7'($urandom);
      setup_wr.signal = 4'($urandom); setup_wr.sugar = 1'($urandom);
      randomize_data();
      cycle("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
